// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the column-serial MixColumns stage: upstream state in,
// downstream result out, plus busy and the FSM state for observation.
interface mix_columns_seq_if;
  // Both sides use strict valid/ready: a transfer happens on a rising clk edge
  // where valid && ready; a valid source holds its data until that edge.
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   state_dbg;

  modport master (
    output in_valid, in_state, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy, state_dbg
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy, state_dbg
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns stage with final-round bypass.
// One 32-bit column per cycle goes through a single combinational column mixer.
module mix_columns (
  input  logic [31:0] col,
  input  logic        inv_en,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a [4];
  logic [7:0] x2[4];
  logic [7:0] x4[4];
  logic [7:0] x8[4];
  logic [7:0] m3[4];
  logic [7:0] m9[4];
  logic [7:0] mb[4];
  logic [7:0] md[4];
  logic [7:0] me[4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    // Row r uses the circulant {2,3,1,1} (forward) or {e,b,d,9} (inverse) rotated by r
    if (inv_en)
      mixed = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
               m9[0] ^ me[1] ^ mb[2] ^ md[3],
               md[0] ^ m9[1] ^ me[2] ^ mb[3],
               mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    else
      mixed = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
               a[0]  ^ x2[1] ^ m3[2] ^ a[3],
               a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
               m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
  end
endmodule

module mix_columns_seq #(
  parameter int NCOL = 4
) (
  input  logic               clk,
  input  logic               rst,
  mix_columns_seq_if.slave   bus
);
  localparam int CW = $clog2(NCOL);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t         state;
  logic [CW-1:0]  col_cnt;
  logic [127:0]   in_buf;
  logic           inv_q;
  logic [31:0]    col_in;
  logic [31:0]    col_out;

  assign col_in        = in_buf[(NCOL-1-int'(col_cnt))*32 +: 32];
  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.state_dbg = state;

  mix_columns u_mix (
    .col    (col_in),
    .inv_en (inv_q),
    .mixed  (col_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      col_cnt       <= '0;
      in_buf        <= '0;
      inv_q         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_state <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // in_ready already folds in out_ready, so DONE can consume and accept together
          if (bus.in_valid && bus.in_ready) begin
            in_buf  <= bus.in_state;
            inv_q   <= bus.in_inv;
            col_cnt <= '0;
            if (bus.in_bypass) begin
              state         <= DONE;
              bus.out_state <= bus.in_state;
              bus.out_valid <= 1'b1;
              bus.busy      <= 1'b0;
            end else begin
              state         <= BUSY;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b1;
            end
          end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        BUSY: begin
          bus.out_state[(NCOL-1-int'(col_cnt))*32 +: 32] <= col_out;
          col_cnt <= col_cnt + 1'b1;
          if (col_cnt == CW'(NCOL-1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: FIPS-197 vectors, inverse, bypass,
// backpressure, mid-operation reset and a back-to-back stream against a GF model.
module tb_mix_columns_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [127:0] FWD_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] FWD_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] REP_IN  = {4{32'hdb135345}};
  localparam logic [127:0] REP_OUT = {4{32'h8e4da1bc}};
  localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_columns_seq_if bus();

  mix_columns_seq #(.NCOL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [127:0] exp_q[$];

  // Reference: generic shift-and-add GF(2^8) multiply with a circulant matrix
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s, input logic inv);
    logic [7:0]   coef[4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[127-32*c-8*j -: 8], coef[(j - row + 4) % 4]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one state, then wait (bounded) for out_valid; edges counts from the accept edge.
  task automatic run_one(input logic [127:0] s, input logic inv, input logic byp,
                         output logic [127:0] got, output int edges);
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_inv    = inv;
    bus.in_bypass = byp;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    got = bus.out_state;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_inv    = 1'b0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    tests_run++;
    if (bus.out_state !== 128'h0) begin tests_failed++; $display("FAIL reset_out_state got=%h exp=0", bus.out_state); end
    tests_run++;
    if (bus.state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
  endtask

  task automatic test_forward();
    int busy_cycles;
    int edges;
    bus.in_valid  = 1'b1;
    bus.in_state  = FWD_IN;
    bus.in_inv    = 1'b0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    busy_cycles = 0;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      if (bus.in_ready === 1'b0 && bus.busy === 1'b1) busy_cycles++;
      tick();
      edges++;
    end
    tests_run++;
    if (edges !== 5) begin tests_failed++; $display("FAIL fwd_latency got=%0d exp=5", edges); end
    tests_run++;
    if (busy_cycles !== 4) begin tests_failed++; $display("FAIL fwd_busy_cycles got=%0d exp=4", busy_cycles); end
    tests_run++;
    if (bus.out_state !== FWD_OUT) begin tests_failed++; $display("FAIL fwd_result got=%h exp=%h", bus.out_state, FWD_OUT); end
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL fwd_return_idle got=%b%b exp=01", bus.out_valid, bus.in_ready);
    end
    tests_run++;
    if (bus.out_state !== FWD_OUT) begin tests_failed++; $display("FAIL fwd_hold_after got=%h exp=%h", bus.out_state, FWD_OUT); end
  endtask

  task automatic test_inverse();
    logic [127:0] got;
    int edges;
    run_one(FWD_OUT, 1'b1, 1'b0, got, edges);
    tests_run++;
    if (got !== FWD_IN) begin tests_failed++; $display("FAIL inv_roundtrip got=%h exp=%h", got, FWD_IN); end
    tests_run++;
    if (edges !== 5) begin tests_failed++; $display("FAIL inv_latency got=%0d exp=5", edges); end
    run_one(REP_IN, 1'b0, 1'b0, got, edges);
    tests_run++;
    if (got !== REP_OUT) begin tests_failed++; $display("FAIL fwd_replicated got=%h exp=%h", got, REP_OUT); end
  endtask

  task automatic test_bypass();
    logic saw_busy;
    bus.in_valid  = 1'b1;
    bus.in_state  = BYP_IN;
    bus.in_inv    = 1'b1;
    bus.in_bypass = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_bypass = 1'b0;
    saw_busy = bus.busy;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL byp_latency out_valid got=%b exp=1", bus.out_valid); end
    tests_run++;
    if (bus.out_state !== BYP_IN) begin tests_failed++; $display("FAIL byp_result got=%h exp=%h", bus.out_state, BYP_IN); end
    tick();
    saw_busy = saw_busy | bus.busy;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== BYP_IN) begin
      tests_failed++; $display("FAIL byp_hold got=%b/%h exp=1/%h", bus.out_valid, bus.out_state, BYP_IN);
    end
    bus.out_ready = 1'b1;
    tick();
    saw_busy = saw_busy | bus.busy;
    tests_run++;
    if (saw_busy !== 1'b0) begin tests_failed++; $display("FAIL byp_busy got=%b exp=0", saw_busy); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL byp_consume got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    int edges;
    int bad;
    bus.in_valid  = 1'b1;
    bus.in_state  = FWD_IN;
    bus.in_inv    = 1'b0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    // Second state held on the input while the first computes and stalls
    bus.in_state = FWD_OUT;
    bus.in_inv   = 1'b1;
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    tests_run++;
    if (edges !== 5) begin tests_failed++; $display("FAIL bp_first_latency got=%0d exp=5", edges); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_state !== FWD_OUT || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL bp_stall_stable got=%0d bad cycles exp=0", bad); end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++; $display("FAIL bp_second_accept got=%b%b exp=01", bus.out_valid, bus.busy);
    end
    edges = 1;
    while (!bus.out_valid && edges < 20) begin
      tick();
      edges++;
    end
    tests_run++;
    if (edges !== 5) begin tests_failed++; $display("FAIL bp_second_latency got=%0d exp=5", edges); end
    tests_run++;
    if (bus.out_state !== FWD_IN) begin tests_failed++; $display("FAIL bp_second_result got=%h exp=%h", bus.out_state, FWD_IN); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    int edges;
    bus.in_valid  = 1'b1;
    bus.in_state  = REP_IN;
    bus.in_inv    = 1'b1;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_ctrl got=%b%b%b exp=001", bus.out_valid, bus.busy, bus.in_ready);
    end
    tests_run++;
    if (bus.out_state !== 128'h0) begin tests_failed++; $display("FAIL midrst_out_state got=%h exp=0", bus.out_state); end
    run_one(FWD_IN, 1'b0, 1'b0, got, edges);
    tests_run++;
    if (got !== FWD_OUT || edges !== 5) begin
      tests_failed++; $display("FAIL midrst_recover got=%h/%0d exp=%h/5", got, edges, FWD_OUT);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] stim[8];
    logic [127:0] exp_v;
    int idx;
    int results;
    int cyc;
    int last_cyc;
    int gap_bad;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      stim[i] = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(model_state(stim[i], i[0]));
    end
    idx = 0;
    results = 0;
    gap_bad = 0;
    last_cyc = -1;
    bus.out_ready = 1'b1;
    bus.in_bypass = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_state  = stim[0];
    bus.in_inv    = 1'b0;
    for (cyc = 0; cyc < 200 && results < 8; cyc++) begin
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) begin
          bus.in_state = stim[idx];
          bus.in_inv   = idx[0];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        tests_run++;
        if (bus.out_state !== exp_v) begin
          tests_failed++; $display("FAIL b2b_result[%0d] got=%h exp=%h", results, bus.out_state, exp_v);
        end
        if (last_cyc >= 0 && cyc - last_cyc != 5) gap_bad++;
        last_cyc = cyc;
        results++;
      end
    end
    tests_run++;
    if (results !== 8 || exp_q.size() !== 0) begin
      tests_failed++; $display("FAIL b2b_count got=%0d left=%0d exp=8/0", results, exp_q.size());
    end
    tests_run++;
    if (gap_bad !== 0) begin tests_failed++; $display("FAIL b2b_spacing got=%0d bad gaps exp=0", gap_bad); end
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
